// File: rtl/spi_reg_bridge_if.sv
// SPI pin bundle plus register-bus signals between spi_reg_bridge and its register file.
// wre is a single-cycle write strobe qualified by addr/din in the same cycle; rdata is combinational from addr.
`timescale 1ns/1ps
interface spi_reg_bridge_if;
    logic       spi_clk;
    logic       spi_csb;
    logic       spi_mosi;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic       wre;
    logic [7:0] addr;
    logic [7:0] din;
    logic [7:0] rdata;
    logic       frame_err;
    logic [2:0] dbg_state;

    modport slave (
        input  spi_clk, spi_csb, spi_mosi, rdata,
        output spi_miso, spi_miso_oe, wre, addr, din, frame_err, dbg_state
    );

    modport master (
        output spi_clk, spi_csb, spi_mosi, rdata,
        input  spi_miso, spi_miso_oe, wre, addr, din, frame_err, dbg_state
    );
endinterface

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave that turns 16-bit frames {rw, a[6:0], data} into register writes and reads.
// All SPI pins are oversampled on sclk; spi_clk edges become one-cycle rise/fall strobes.
`timescale 1ns/1ps
module spi_reg_bridge #(
    parameter int REGCOUNT    = 14,
    parameter int SYNC_STAGES = 2
) (
    input  logic              sclk,
    input  logic              rstn,
    spi_reg_bridge_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CMD    = 3'd1,
        WDATA  = 3'd2,
        WRITE  = 3'd3,
        RDLOAD = 3'd4,
        RDATA  = 3'd5,
        DONE   = 3'd6
    } state_t;

    localparam logic [7:0] REG_LIM = 8'(REGCOUNT);

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_csb_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_clk_d;

    state_t      r_state;
    state_t      w_next;
    logic        w_abort;
    logic [4:0]  r_bitcnt;
    logic [6:0]  r_shift;
    logic [7:0]  r_addr;
    logic [7:0]  r_din;
    logic [7:0]  r_tx;
    logic        r_miso;
    logic        r_ferr;

    logic w_clk_s;
    logic w_csb;
    logic w_mosi;
    logic w_rise;
    logic w_fall;
    logic w_in_range;

    // Reset parks the synchronizers in the idle-bus condition: csb high, clock and data low.
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            r_clk_sync  <= '0;
            r_csb_sync  <= '1;
            r_mosi_sync <= '0;
            r_clk_d     <= 1'b0;
        end else begin
            r_clk_sync[0]  <= bus.spi_clk;
            r_csb_sync[0]  <= bus.spi_csb;
            r_mosi_sync[0] <= bus.spi_mosi;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_clk_sync[i]  <= r_clk_sync[i-1];
                r_csb_sync[i]  <= r_csb_sync[i-1];
                r_mosi_sync[i] <= r_mosi_sync[i-1];
            end
            r_clk_d <= w_clk_s;
        end
    end

    assign w_clk_s    = r_clk_sync[SYNC_STAGES-1];
    assign w_csb      = r_csb_sync[SYNC_STAGES-1];
    assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
    assign w_rise     = w_clk_s & ~r_clk_d;
    assign w_fall     = ~w_clk_s & r_clk_d;
    assign w_in_range = (r_addr < REG_LIM);

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // A 16th rise completing a frame wins over csb going high in the same cycle.
    always_comb begin
        w_next  = r_state;
        w_abort = 1'b0;
        case (r_state)
            IDLE:    if (!w_csb) w_next = CMD;
            CMD: begin
                if (w_csb) begin
                    w_next  = IDLE;
                    w_abort = 1'b1;
                end else if (w_rise && r_bitcnt == 5'd7) begin
                    w_next = r_shift[6] ? RDLOAD : WDATA;
                end
            end
            WDATA: begin
                if (w_rise && r_bitcnt == 5'd15) begin
                    w_next = WRITE;
                end else if (w_csb) begin
                    w_next  = IDLE;
                    w_abort = 1'b1;
                end
            end
            WRITE:   w_next = DONE;
            RDLOAD: begin
                if (w_csb) begin
                    w_next  = IDLE;
                    w_abort = 1'b1;
                end else begin
                    w_next = RDATA;
                end
            end
            RDATA: begin
                if (w_rise && r_bitcnt == 5'd15) begin
                    w_next = DONE;
                end else if (w_csb) begin
                    w_next  = IDLE;
                    w_abort = 1'b1;
                end
            end
            DONE:    if (w_csb) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            r_bitcnt <= 5'd0;
            r_shift  <= 7'd0;
            r_addr   <= 8'h00;
            r_din    <= 8'h00;
            r_tx     <= 8'h00;
            r_miso   <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            r_ferr <= w_abort;
            case (r_state)
                IDLE: if (!w_csb) r_bitcnt <= 5'd0;
                CMD: begin
                    if (w_rise && !w_abort) begin
                        r_shift  <= {r_shift[5:0], w_mosi};
                        r_bitcnt <= r_bitcnt + 5'd1;
                        if (r_bitcnt == 5'd7) r_addr <= {1'b0, r_shift[5:0], w_mosi};
                    end
                end
                WDATA: begin
                    if (w_rise && !w_abort) begin
                        r_shift  <= {r_shift[5:0], w_mosi};
                        r_bitcnt <= r_bitcnt + 5'd1;
                        if (r_bitcnt == 5'd15) r_din <= {r_shift, w_mosi};
                    end
                end
                RDLOAD: begin
                    r_tx   <= w_in_range ? bus.rdata : 8'h00;
                    r_miso <= 1'b0;
                end
                RDATA: begin
                    if (w_rise) r_bitcnt <= r_bitcnt + 5'd1;
                    // The 8th fall presents the MSB; every later fall advances one bit.
                    if (w_fall) begin
                        if (r_bitcnt == 5'd8) begin
                            r_miso <= r_tx[7];
                        end else if (r_bitcnt > 5'd8) begin
                            r_tx   <= {r_tx[6:0], 1'b0};
                            r_miso <= r_tx[6];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.wre         = (r_state == WRITE) && w_in_range;
    assign bus.addr        = r_addr;
    assign bus.din         = r_din;
    assign bus.spi_miso    = (r_state == RDATA) && r_miso;
    assign bus.spi_miso_oe = (r_state == RDATA);
    assign bus.frame_err   = r_ferr;
    assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Bench for spi_reg_bridge: SPI master driver, register-file model and queue-based scoreboard.
`timescale 1ns/1ps
module tb_spi_reg_bridge;
    localparam int REGCOUNT = 14;
    localparam int HALF     = 8;

    logic sclk = 1'b0;
    logic rstn;
    always #5 sclk = ~sclk;

    spi_reg_bridge_if bus();

    spi_reg_bridge #(.REGCOUNT(REGCOUNT), .SYNC_STAGES(2)) dut (
        .sclk (sclk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int ferr_cnt = 0;
    int exp_ferr = 0;

    logic [15:0] exp_q[$];
    logic [7:0]  rd_exp_q[$];

    logic [7:0] env_regs[0:127];
    logic [7:0] ref_mem[0:REGCOUNT-1];
    logic       env_loaded = 1'b0;

    function automatic logic [7:0] init_val(input int i);
        return 8'(i * 37 + 5);
    endfunction

    // Register file attached to the bridge: reads are combinational, writes land on wre.
    assign bus.rdata = env_regs[bus.addr[6:0]];
    always @(posedge sclk) begin
        if (!env_loaded) begin
            for (int i = 0; i < 128; i++) env_regs[i] = init_val(i);
            env_loaded = 1'b1;
        end else if (bus.wre) begin
            env_regs[bus.addr[6:0]] = bus.din;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Write-strobe and frame_err monitor.
    always @(negedge sclk) begin
        if (bus.wre === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL wre_unexpected actual addr=%0h din=%0h required no write at %0t",
                         bus.addr, bus.din, $time);
            end else begin
                check("wre_addr_din", {16'h0, bus.addr, bus.din}, {16'h0, exp_q.pop_front()});
            end
        end
        if (bus.frame_err === 1'b1) ferr_cnt++;
    end

    // MISO monitor: samples on the master's own rising edges.
    int         rise_idx = 0;
    logic       frame_rd = 1'b0;
    logic [7:0] cap      = 8'h00;
    always @(posedge bus.spi_clk or posedge bus.spi_csb) begin
        if (bus.spi_csb) begin
            rise_idx = 0;
        end else begin
            rise_idx++;
            if (rise_idx == 1) frame_rd = bus.spi_mosi;
            if (frame_rd && rise_idx >= 9 && rise_idx <= 16) begin
                check("miso_oe_read", {31'h0, bus.spi_miso_oe}, 32'h1);
                cap = {cap[6:0], bus.spi_miso};
                if (rise_idx == 16) begin
                    if (rd_exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL read_unexpected actual=%0h required no read", cap);
                    end else begin
                        check("read_data", {24'h0, cap}, {24'h0, rd_exp_q.pop_front()});
                    end
                end
            end else begin
                check("miso_idle", {30'h0, bus.spi_miso_oe, bus.spi_miso}, 32'h0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge sclk);
    endtask

    task automatic spi_bits(input logic [31:0] val, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            bus.spi_mosi = val[i];
            tick(HALF);
            bus.spi_clk = 1'b1;
            tick(HALF);
            bus.spi_clk = 1'b0;
        end
    endtask

    task automatic frame_start();
        bus.spi_csb = 1'b0;
        tick(HALF);
    endtask

    task automatic frame_end();
        tick(HALF);
        bus.spi_csb  = 1'b1;
        bus.spi_mosi = 1'b0;
        tick(3 * HALF);
    endtask

    // Reference model: what a complete 16-bit frame must do to the register space.
    task automatic model_frame(input logic [15:0] w);
        logic       rw;
        logic [6:0] a;
        logic [7:0] d;
        rw = w[15];
        a  = w[14:8];
        d  = w[7:0];
        if (!rw) begin
            if (int'(a) < REGCOUNT) begin
                ref_mem[a] = d;
                exp_q.push_back({1'b0, a, d});
            end
        end else begin
            rd_exp_q.push_back((int'(a) < REGCOUNT) ? ref_mem[a] : 8'h00);
        end
    endtask

    task automatic send_frame(input logic [15:0] w);
        model_frame(w);
        frame_start();
        spi_bits({16'h0, w}, 16);
        frame_end();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wre"},  {31'h0, bus.wre},         32'h0);
        check({tag, "_addr"}, {24'h0, bus.addr},        32'h0);
        check({tag, "_din"},  {24'h0, bus.din},         32'h0);
        check({tag, "_miso"}, {31'h0, bus.spi_miso},    32'h0);
        check({tag, "_oe"},   {31'h0, bus.spi_miso_oe}, 32'h0);
        check({tag, "_ferr"}, {31'h0, bus.frame_err},   32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       rw;
        logic [6:0] a;
        logic [7:0] d;

        for (int i = 0; i < REGCOUNT; i++) ref_mem[i] = init_val(i);
        rstn        = 1'b0;
        bus.spi_csb  = 1'b1;
        bus.spi_clk  = 1'b0;
        bus.spi_mosi = 1'b0;
        tick(5);
        check_reset_outputs("reset");
        rstn = 1'b1;
        tick(5);

        send_frame(16'h0182);
        send_frame(16'h0D2A);
        send_frame(16'h8D00);
        send_frame(16'h2055);
        send_frame(16'hA000);

        // Write aborted after 10 bits.
        frame_start();
        spi_bits(32'(16'h0377 >> 6), 10);
        frame_end();
        exp_ferr++;
        check("ferr_after_abort", ferr_cnt, exp_ferr);
        send_frame(16'h0033);

        // 20-bit frame: trailing 4 bits must be ignored.
        model_frame(16'h0C7F);
        frame_start();
        spi_bits({12'h0, 16'h0C7F, 4'hA}, 20);
        frame_end();

        // Reset in the middle of a write.
        frame_start();
        spi_bits(32'(16'h0142 >> 4), 12);
        rstn = 1'b0;
        tick(2);
        check_reset_outputs("midreset");
        bus.spi_csb = 1'b1;
        tick(2);
        rstn = 1'b1;
        tick(4 * HALF);
        check("ferr_after_reset", ferr_cnt, exp_ferr);
        send_frame(16'h0101);
        check("addr_hold", {24'h0, bus.addr}, 32'h01);
        check("din_hold",  {24'h0, bus.din},  32'h01);

        repeat (40) begin
            rw = 1'($urandom_range(0, 1));
            a  = 7'($urandom_range(0, 20));
            d  = 8'($urandom);
            send_frame({rw, a, d});
        end

        tick(20);
        check("wre_queue_drained",  exp_q.size(),    0);
        check("read_queue_drained", rd_exp_q.size(), 0);
        check("ferr_total",         ferr_cnt,        exp_ferr);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
